// File: rtl/sm_pkg.sv
// sm_pkg: shared definitions for the sign-magnitude subtract accumulator.
// Holds the frame FSM state enum, the default operand width, and helpers
// that derive the sign-bit index and magnitude width from a width N.
package sm_pkg;

  localparam int unsigned SM_N = 32'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } sm_state_e;

  // Index of the sign bit in an N-bit sign-magnitude word.
  function automatic int unsigned sm_sign_idx(input int unsigned n);
    return n - 32'd1;
  endfunction

  // Number of magnitude bits in an N-bit sign-magnitude word.
  function automatic int unsigned sm_mag_w(input int unsigned n);
    return n - 32'd1;
  endfunction

  localparam int unsigned SM_SIGN_BIT = sm_sign_idx(SM_N);
  localparam int unsigned SM_MAG_W    = sm_mag_w(SM_N);

endpackage

// File: rtl/sm_addsub_core.sv
// sm_addsub_core: combinational sign-magnitude adder/subtractor.
// Ports:
//   i_a   [N-1:0] left operand (sign-magnitude)
//   i_b   [N-1:0] right operand (sign-magnitude)
//   i_sub         1 = compute a - b, 0 = compute a + b
//   o_y   [N-1:0] result, a zero magnitude is always returned as +0
//   o_ovf         magnitude overflow (only possible for same-sign addition)
module sm_addsub_core
  import sm_pkg::*;
#(
  parameter int unsigned N = SM_N
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_sub,
  output logic [N-1:0] o_y,
  output logic         o_ovf
);

  localparam int unsigned SB = sm_sign_idx(N);
  localparam int unsigned MW = sm_mag_w(N);

  logic          w_sa;
  logic          w_sb;
  logic [MW-1:0] w_ma;
  logic [MW-1:0] w_mb;
  logic [MW:0]   w_sum;
  logic [MW-1:0] w_mag;
  logic          w_sign;

  // Subtraction is an addition with the right operand's sign inverted.
  always_comb begin
    w_sa   = i_a[SB];
    w_sb   = i_b[SB] ^ i_sub;
    w_ma   = i_a[MW-1:0];
    w_mb   = i_b[MW-1:0];
    w_sum  = {1'b0, w_ma} + {1'b0, w_mb};
    w_mag  = {MW{1'b0}};
    w_sign = 1'b0;
    o_ovf  = 1'b0;
    if (w_sa == w_sb) begin
      // Same sign: magnitudes add, carry out is the overflow and is dropped.
      w_mag  = w_sum[MW-1:0];
      w_sign = w_sa;
      o_ovf  = w_sum[MW];
    end else if (w_ma >= w_mb) begin
      w_mag  = w_ma - w_mb;
      w_sign = w_sa;
    end else begin
      w_mag  = w_mb - w_ma;
      w_sign = w_sb;
    end
    // Never produce -0.
    if (w_mag == {MW{1'b0}}) begin
      o_y = {N{1'b0}};
    end else begin
      o_y = {w_sign, w_mag};
    end
  end

endmodule

// File: rtl/sm_sub_accumulator.sv
// sm_sub_accumulator: frame-based sign-magnitude subtract accumulator.
// The first beat of a frame loads the accumulator; each further beat is
// subtracted from it. The in_last beat moves the result to the output,
// where it is held until the consumer accepts it.
// Ports:
//   clk, rst               rising-edge clock, async active-high reset
//   in_valid/in_ready      operand beat handshake
//   in_data [N-1:0]        sign-magnitude operand
//   in_last                final operand of the frame
//   out_valid/out_ready    result handshake
//   out_data [N-1:0]       sign-magnitude frame result
//   out_ovf                sticky magnitude overflow for the frame
module sm_sub_accumulator
  import sm_pkg::*;
#(
  parameter int unsigned N = SM_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_ovf
);

  sm_state_e    r_state;
  logic [N-1:0] r_acc;
  logic         r_ovf;
  logic         r_in_ready;
  logic         r_out_valid;
  logic [N-1:0] r_out_data;
  logic         r_out_ovf;

  logic         w_loading;
  logic         w_accept;
  logic [N-1:0] w_core_a;
  logic [N-1:0] w_result;
  logic         w_core_ovf;
  logic         w_ovf_next;

  // Loading is an add of in_data to +0, which also normalises a -0 operand.
  always_comb begin
    w_loading = (r_state == IDLE);
    w_accept  = in_valid & r_in_ready;
    if (w_loading) begin
      w_core_a   = {N{1'b0}};
      w_ovf_next = w_core_ovf;
    end else begin
      w_core_a   = r_acc;
      w_ovf_next = r_ovf | w_core_ovf;
    end
  end

  sm_addsub_core #(
    .N (N)
  ) u_core (
    .i_a   (w_core_a),
    .i_b   (in_data),
    .i_sub (~w_loading),
    .o_y   (w_result),
    .o_ovf (w_core_ovf)
  );

  // Frame FSM with registered handshake and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_acc       <= {N{1'b0}};
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= {N{1'b0}};
      r_out_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE, ACC: begin
          if (w_accept) begin
            r_acc <= w_result;
            r_ovf <= w_ovf_next;
            if (in_last) begin
              r_state     <= HOLD;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
              r_out_data  <= w_result;
              r_out_ovf   <= w_ovf_next;
            end else begin
              r_state <= ACC;
            end
          end
        end
        HOLD: begin
          // in_ready is still 0 on the handshake edge, so no beat can slip in.
          if (out_ready) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_sm_sub_accumulator.sv
module tb_sm_sub_accumulator;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_ovf;

  int checks   = 0;
  int failures = 0;

  sm_sub_accumulator #(.N(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%02h expected=0x%02h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain signed integers, magnitude wrapped modulo 128.
  function automatic int sm_to_int(input logic [7:0] v);
    int m;
    m = int'(v[6:0]);
    return v[7] ? -m : m;
  endfunction

  function automatic logic [7:0] int_to_sm(input int v);
    int m;
    m = (v < 0) ? -v : v;
    if (m == 0) return 8'h00;
    return {(v < 0), m[6:0]};
  endfunction

  int         m_val;
  bit         m_active;
  bit         m_ovf;
  bit         m_hold;
  logic [7:0] m_out_data;
  bit         m_out_ovf;

  always @(posedge clk or posedge rst) begin
    int s;
    int mag;
    if (rst) begin
      m_val = 0; m_active = 0; m_ovf = 0; m_hold = 0;
      m_out_data = 8'h00; m_out_ovf = 0;
    end else if (m_hold) begin
      if (out_ready) m_hold = 0;
    end else if (in_valid) begin
      if (!m_active) begin
        m_val = sm_to_int(in_data);
        m_ovf = 0;
      end else begin
        s   = m_val - sm_to_int(in_data);
        mag = (s < 0) ? -s : s;
        if (mag > 127) begin
          m_ovf = 1;
          mag   = mag % 128;
        end
        m_val = (s < 0) ? -mag : mag;
      end
      if (in_last) begin
        m_hold     = 1;
        m_active   = 0;
        m_out_data = int_to_sm(m_val);
        m_out_ovf  = m_ovf;
      end else begin
        m_active = 1;
      end
    end
  end

  // Cycle-by-cycle comparison against the model on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      check1("rst_out_valid", out_valid, 1'b0);
      check8("rst_out_data", out_data, 8'h00);
      check1("rst_out_ovf", out_ovf, 1'b0);
    end else begin
      check1("mdl_out_valid", out_valid, m_hold);
      check1("mdl_in_ready", in_ready, !m_hold);
      if (m_hold) begin
        check8("mdl_out_data", out_data, m_out_data);
        check1("mdl_out_ovf", out_ovf, m_out_ovf);
      end
    end
  end

  task automatic send_beat(input logic [7:0] d, input logic l);
    int n;
    in_valid = 1'b1; in_data = d; in_last = l; n = 0;
    while (1) begin
      @(negedge clk);
      if (in_ready === 1'b1) break;
      n++;
      if (n > 20) begin
        check1("beat_timeout", 1'b0, 1'b1);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
  endtask

  // Called right after the last beat: the result must be valid one cycle on.
  task automatic expect_result(input logic [7:0] d, input logic o, input string name);
    @(negedge clk);
    check1({name, "_valid"}, out_valid, 1'b1);
    check8({name, "_data"}, out_data, d);
    check1({name, "_ovf"}, out_ovf, o);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic frame2(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] d, input logic o, input string name);
    send_beat(a, 1'b0);
    send_beat(b, 1'b1);
    expect_result(d, o, name);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; out_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check1("post_rst_in_ready", in_ready, 1'b1);
    check1("post_rst_out_valid", out_valid, 1'b0);
    @(posedge clk); #1;

    frame2(8'h0A, 8'h03, 8'h07, 1'b0, "pos7");
    frame2(8'h03, 8'h0A, 8'h87, 1'b0, "neg7");
    frame2(8'h05, 8'h05, 8'h00, 1'b0, "zero");
    frame2(8'hE4, 8'h32, 8'h96, 1'b1, "ovf_wrap");
    frame2(8'h10, 8'h01, 8'h0F, 1'b0, "ovf_cleared");
    frame2(8'hC0, 8'h40, 8'h00, 1'b1, "wrap_to_zero");

    send_beat(8'h80, 1'b1);
    expect_result(8'h00, 1'b0, "single_neg0");
    send_beat(8'hFF, 1'b1);
    expect_result(8'hFF, 1'b0, "single_ff");

    // 5 - (-5) - 32 = -22, with idle gaps between beats
    send_beat(8'h05, 1'b0);
    idle(2);
    send_beat(8'h85, 1'b0);
    idle(3);
    send_beat(8'h20, 1'b1);
    expect_result(8'h96, 1'b0, "gaps");

    // Back-pressure: result held for 3 cycles, then a beat offered in the
    // handshake cycle must wait one more cycle.
    send_beat(8'h7F, 1'b0);
    send_beat(8'h01, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check1("hold_valid", out_valid, 1'b1);
      check8("hold_data", out_data, 8'h7E);
      check1("hold_in_ready", in_ready, 1'b0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h02; in_last = 1'b0;
    @(negedge clk);
    check1("hs_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check1("after_hs_in_ready", in_ready, 1'b1);
    check1("after_hs_out_valid", out_valid, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = 8'h00;
    send_beat(8'h03, 1'b1);
    expect_result(8'h81, 1'b0, "hold_next");

    // Reset in the middle of a frame discards it.
    send_beat(8'h11, 1'b0);
    send_beat(8'h22, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check1("midrst_out_valid", out_valid, 1'b0);
    check8("midrst_out_data", out_data, 8'h00);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check1("midrst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    frame2(8'h14, 8'h04, 8'h10, 1'b0, "after_rst");

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sm_sub_accumulator.md
SM_SUB_ACCUMULATOR -- requirements
Module: sm_sub_accumulator

Interface
REQ-001 Parameter N, default 8: operand and result width in sign-magnitude format; bit N-1 is the sign (1 = negative) and bits N-2:0 are the magnitude.
REQ-002 The module SHALL run on one clock and use an asynchronous, active-high reset.
REQ-003 clk  input  1  Rising-edge clock.
REQ-004 rst  input  1  Asynchronous, active-high reset.
REQ-005 in_valid  input  1  Operand beat valid.
REQ-006 in_ready  output  1  Block can accept an operand beat.
REQ-007 in_data  input  N  Sign-magnitude operand.
REQ-008 in_last  input  1  Marks the final operand of a frame.
REQ-009 out_valid  output  1  Result valid.
REQ-010 out_ready  input  1  Consumer accepts the result.
REQ-011 out_data  output  N  Sign-magnitude result of the frame.
REQ-012 out_ovf  output  1  Sticky flag: a magnitude overflow occurred during the frame.

Function
REQ-013 A beat SHALL be accepted on a rising clk edge where in_valid and in_ready are both 1; a result SHALL be consumed on a rising edge where out_valid and out_ready are both 1.
REQ-014 The FSM SHALL have three states: IDLE (no frame active), ACC (frame in progress) and HOLD (result presented).
REQ-015 In IDLE, an accepted beat SHALL load acc <= in_data and clear ovf; the next state SHALL be HOLD if in_last = 1, otherwise ACC.
REQ-016 In ACC, each accepted beat SHALL compute acc <= acc - in_data in sign-magnitude arithmetic, equivalent to a sign-magnitude add of in_data with its sign bit inverted; on in_last the FSM SHALL go to HOLD.
REQ-017 Same-sign addition: if the sum of the magnitudes exceeds 2^(N-1)-1, ovf SHALL be set and remain set for the frame, and the magnitude SHALL wrap modulo 2^(N-1).
REQ-018 Opposite-sign addition: the result SHALL be the larger magnitude minus the smaller, carrying the sign of the larger-magnitude operand; this case can never overflow.
REQ-019 Any zero magnitude result SHALL be normalised to +0 (all bits 0); this applies to the loaded first operand as well.
REQ-020 in_ready SHALL be 1 in IDLE and ACC and 0 in HOLD.
REQ-021 out_valid SHALL be 1 only in HOLD; it SHALL rise in the cycle after the in_last beat is accepted, giving a latency of 1 cycle.
REQ-022 out_data and out_ovf SHALL be registered and SHALL stay stable while out_valid = 1 and out_ready = 0.
REQ-023 On the result handshake, the FSM SHALL go to IDLE; a new frame's first beat SHALL be accepted no earlier than the following cycle.
REQ-024 in_valid = 0 in ACC SHALL leave acc, ovf and the state unchanged; the number of beats per frame is unbounded.

Reset
REQ-025 While rst = 1, the state SHALL be IDLE and acc, out_data, out_ovf and out_valid SHALL be 0; in_ready SHALL be 1 after rst is released.
REQ-026 Reset during ACC or HOLD SHALL discard the partial frame or pending result; the first beat after reset SHALL start a fresh frame.

Structure
REQ-027 A shared package sm_pkg SHALL hold the FSM state enum (IDLE, ACC, HOLD) and the sign-bit index and magnitude-width localparams derived from N.
REQ-028 A combinational sub-module sm_addsub_core SHALL perform the sign-magnitude add/subtract, including the overflow flag and the zero normalisation; the top level SHALL hold only the FSM, registers and handshake logic.

Verification (N = 8)
REQ-029 Frame {0x0A, last 0x03}: out_data SHALL be 0x07 (+7) and out_ovf 0, with out_valid asserted 1 cycle after the last beat.
REQ-030 Frame {0x03, last 0x0A}: out_data SHALL be 0x87 (-7); frame {0x05, last 0x05}: out_data SHALL be 0x00, never 0x80.
REQ-031 Frame {0xE4 (-100), last 0x32 (+50)}: out_data SHALL be 0x96 (magnitude 150 wrapped to 22, negative) and out_ovf 1; the next frame SHALL start with out_ovf 0.
REQ-032 Single-beat frame {last 0x80}: out_data SHALL be 0x00; single-beat frame {last 0xFF}: out_data SHALL be 0xFF.
REQ-033 out_ready held at 0 for 3 cycles in HOLD: out_data SHALL be stable and in_ready 0 throughout; a beat presented in the handshake cycle SHALL NOT be accepted, and the same beat SHALL be accepted in the next cycle.
REQ-034 rst pulsed after 2 beats of an unfinished frame: outputs SHALL match the REQ-025 values; a following frame {0x14, last 0x04} SHALL produce 0x10 (+16).
